sum_accumulator: RTL

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator_if.sv | 25 ++
 rtl/sum_accumulator.sv | 93 +++++++++
 2 files changed

// File: rtl/sum_accumulator_if.sv
// Sample/total handshake bundle between the upstream adder, the burst
// accumulator and its downstream consumer.
interface sum_accumulator_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
);
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] total;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sum, cout, in_valid, out_ready,
    input  in_ready, total, ovf, out_valid
  );

  modport slave (
    input  sum, cout, in_valid, out_ready,
    output in_ready, total, ovf, out_valid
  );
endinterface

// File: rtl/sum_accumulator.sv
// Burst accumulator: sums BURST samples of {cout,sum} and hands off the total
// with a sticky overflow flag. Define SUM_ACC_SAT_EN to saturate instead of wrap.
//
//   state | meaning
//   ACCUM | accepting samples, in_ready=1
//   HOLD  | total/ovf presented, out_valid=1, waiting for out_ready
module sum_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int BURST = 8
) (
  input logic         clk,
  input logic         rst,
  sum_accumulator_if.slave bus
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sample_ext;
  logic [ACC_W:0]   acc_sum;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;

  assign sample_ext = {{(ACC_W - WIDTH){1'b0}}, bus.cout, bus.sum};
  assign acc_sum    = {1'b0, acc_q} + sample_ext;
  assign add_ovf    = acc_sum[ACC_W];

`ifdef SUM_ACC_SAT_EN
  // once clamped, any further sample overflows again, so acc stays at max
  assign acc_next = add_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
  assign acc_next = acc_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d = acc_next;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // handshake outputs come straight from the state register
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.total     = acc_q;
  assign bus.ovf       = ovf_q;

endmodule
